// File: rtl/mips_cpu_load_sequencer_if.sv
// Avalon-style read-only data bus between the load sequencer (master) and data memory (slave).
// Combinational bundle; no latency. The slave stalls the master with waitrequest.
interface mips_cpu_load_sequencer_if;
   logic [31:0] address;
   logic        read;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (output address, read, byteenable, input waitrequest, readdata);
   modport slave  (input address, read, byteenable, output waitrequest, readdata);
endinterface

// File: rtl/mips_cpu_load_sequencer.sv
// Load sequencer: one word read per load, then lane select/extend/LWL-LWR merge; done 2 cycles after start plus wait states.
// Holds the read through waitrequest (optional timeout); MIPS_LOAD_ALIGN_CHECK_EN rejects misaligned LH/LHU/LW.
module mips_cpu_load_sequencer #(
   parameter int WAIT_TIMEOUT = 255,
   parameter int TO_W         = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        ready,
   input  logic [31:0] addr,
   input  logic [2:0]  ctrl,
   input  logic [31:0] rt_old,
   output logic        done,
   output logic        err,
   output logic [31:0] result,
   mips_cpu_load_sequencer_if.master avm
);

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LBU = 3'b001;
   localparam logic [2:0] LD_LH  = 3'b010;
   localparam logic [2:0] LD_LHU = 3'b011;
   localparam logic [2:0] LD_BAD = 3'b100;
   localparam logic [2:0] LD_LW  = 3'b101;
   localparam logic [2:0] LD_LWL = 3'b110;
   localparam logic [2:0] LD_LWR = 3'b111;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(WAIT_TIMEOUT);

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t          state, state_nxt;
   logic [31:0]     addr_q;
   logic [31:0]     rt_q;
   logic [2:0]      ctrl_q;
   logic [TO_W-1:0] wait_cnt;
   logic [TO_W-1:0] wait_inc;
   logic            bad_req;
   logic            timeout;

   function automatic logic [31:0] shape(input logic [2:0] c, input logic [1:0] off,
                                         input logic [31:0] m, input logic [31:0] rt);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = m[{off, 3'b000} +: 8];
      h = off[1] ? m[31:16] : m[15:0];
      r = m;
      case (c)
         LD_LB:  r = {{24{b[7]}}, b};
         LD_LBU: r = {24'd0, b};
         LD_LH:  r = {{16{h[15]}}, h};
         LD_LHU: r = {16'd0, h};
         LD_LWL: begin
            case (off)
               2'd0:    r = {m[7:0],  rt[23:0]};
               2'd1:    r = {m[15:0], rt[15:0]};
               2'd2:    r = {m[23:0], rt[7:0]};
               default: r = m;
            endcase
         end
         LD_LWR: begin
            case (off)
               2'd0:    r = m;
               2'd1:    r = {rt[31:24], m[31:8]};
               2'd2:    r = {rt[31:16], m[31:16]};
               default: r = {rt[31:8],  m[31:24]};
            endcase
         end
         default: r = m;
      endcase
      return r;
   endfunction

   // Requests that never touch the bus: invalid type, plus misaligned ones when checking is built in.
   always_comb begin
      bad_req = (ctrl == LD_BAD);
`ifdef MIPS_LOAD_ALIGN_CHECK_EN
      if ((ctrl == LD_LH || ctrl == LD_LHU) && addr[0])
         bad_req = 1'b1;
      if (ctrl == LD_LW && addr[1:0] != 2'b00)
         bad_req = 1'b1;
`endif
   end

   assign wait_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
   assign timeout  = (WAIT_TIMEOUT != 0) && avm.waitrequest && (wait_inc == TO_LIM);

   assign avm.address = {addr_q[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      ready          = 1'b0;
      done           = 1'b0;
      avm.read       = 1'b0;
      avm.byteenable = 4'b0000;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start)
               state_nxt = bad_req ? DONE : READ;
         end
         READ: begin
            avm.read       = 1'b1;
            avm.byteenable = 4'b1111;
            if (!avm.waitrequest || timeout)
               state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= '0;
         rt_q     <= '0;
         ctrl_q   <= '0;
         wait_cnt <= '0;
         err      <= 1'b0;
         result   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q   <= addr;
                  ctrl_q   <= ctrl;
                  rt_q     <= rt_old;
                  wait_cnt <= '0;
                  err      <= bad_req;
                  if (bad_req)
                     result <= '0;
               end
            end
            READ: begin
               if (!avm.waitrequest) begin
                  result <= shape(ctrl_q, addr_q[1:0], avm.readdata, rt_q);
               end else begin
                  wait_cnt <= wait_inc;
                  if (timeout) begin
                     err    <= 1'b1;
                     result <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_load_sequencer.sv
// Bench for mips_cpu_load_sequencer: directed and random loads against an arithmetic reference model,
// with a stalling memory slave, ignored-start noise, timeout and mid-read reset.
module tb_mips_cpu_load_sequencer;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        ready;
   logic [31:0] addr;
   logic [2:0]  ctrl;
   logic [31:0] rt_old;
   logic        done;
   logic        err;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   mips_cpu_load_sequencer_if bus ();

   mips_cpu_load_sequencer #(.WAIT_TIMEOUT(TO), .TO_W(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .ready  (ready),
      .addr   (addr),
      .ctrl   (ctrl),
      .rt_old (rt_old),
      .done   (done),
      .err    (err),
      .result (result),
      .avm    (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: lane extraction and merges as shifts/masks on the whole word.
   function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] rt, input logic [31:0] m);
      int          off;
      logic [31:0] ones;
      logic [7:0]  b;
      logic [15:0] h;
      logic signed [31:0] s;
      off  = int'(a % 4);
      ones = '1;
      b    = 8'(m >> (8 * off));
      h    = 16'(m >> (16 * (off / 2)));
      case (c)
         3'd0: begin s = 32'(signed'(b)); return s; end
         3'd1: return 32'(b);
         3'd2: begin s = 32'(signed'(h)); return s; end
         3'd3: return 32'(h);
         3'd6: return (m << (8 * (3 - off))) | (rt & (ones >> (8 * (off + 1))));
         3'd7: return (m >> (8 * off)) | (rt & ~(ones >> (8 * off)));
         default: return m;
      endcase
   endfunction

   function automatic bit rejected(input logic [2:0] c, input logic [31:0] a);
      bit r;
      r = (c == 3'd4);
`ifdef MIPS_LOAD_ALIGN_CHECK_EN
      if ((c == 3'd2 || c == 3'd3) && (a % 2) != 0) r = 1'b1;
      if (c == 3'd5 && (a % 4) != 0) r = 1'b1;
`endif
      return r;
   endfunction

   task automatic do_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rt,
                          input logic [31:0] m, input int nwait, input bit noise);
      int          exp_reads, exp_cyc, cyc, reads, first_rd;
      bit          exp_err, got_done;
      logic [31:0] exp_res;
      if (rejected(c, a)) begin
         exp_reads = 0; exp_cyc = 1; exp_err = 1'b1; exp_res = '0;
      end else if (nwait >= TO) begin
         exp_reads = TO; exp_cyc = TO + 1; exp_err = 1'b1; exp_res = '0;
      end else begin
         exp_reads = nwait + 1; exp_cyc = nwait + 2; exp_err = 1'b0;
         exp_res = ref_load(c, a, rt, m);
      end

      @(negedge clk);
      chk("ready_idle", 32'(ready), 32'd1);
      start = 1'b1; addr = a; ctrl = c; rt_old = rt;
      bus.waitrequest = (nwait > 0);
      bus.readdata    = (nwait > 0) ? $urandom : m;
      @(posedge clk);
      #1 start = 1'b0;

      cyc = 0; reads = 0; first_rd = 0; got_done = 1'b0;
      while (!got_done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.read) begin
            reads++;
            if (reads == 1) first_rd = cyc;
            chk("avm_address", bus.address, {a[31:2], 2'b00});
            chk("avm_byteenable", 32'(bus.byteenable), 32'hF);
         end
         if (done) begin
            got_done = 1'b1;
            chk("done_cycle", 32'(cyc), 32'(exp_cyc));
            chk("err", 32'(err), 32'(exp_err));
            chk("result", result, exp_res);
         end else begin
            bus.waitrequest = (reads <= nwait);
            bus.readdata    = bus.waitrequest ? $urandom : m;
         end
         if (noise) begin
            start = 1'($urandom_range(0, 1)); addr = $urandom; ctrl = 3'($urandom);
            rt_old = $urandom;
         end
      end
      if (!got_done) chk("done_seen", 32'd0, 32'd1);
      chk("read_count", 32'(reads), 32'(exp_reads));
      if (reads > 0) chk("first_read_cycle", 32'(first_rd), 32'd1);

      // A start during DONE must not launch anything; outputs hold.
      @(negedge clk);
      chk("post_ready", 32'(ready), 32'd1);
      chk("post_no_read", 32'(bus.read), 32'd0);
      chk("post_done_low", 32'(done), 32'd0);
      chk("hold_result", result, exp_res);
      chk("hold_err", 32'(err), 32'(exp_err));
      start = 1'b0;
      bus.waitrequest = 1'b0;
   endtask

   task automatic reset_mid_read();
      int seen_done;
      @(negedge clk);
      start = 1'b1; addr = 32'h0000_4000; ctrl = 3'd5; rt_old = '0;
      bus.waitrequest = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_read_before", 32'(bus.read), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_read", 32'(bus.read), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_address", bus.address, 32'd0);
      reset = 1'b0;
      bus.waitrequest = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      chk("rst_no_done", 32'(seen_done), 32'd0);
   endtask

   initial begin
      int nw;
      reset = 1'b1; start = 1'b0; addr = '0; ctrl = '0; rt_old = '0;
      bus.waitrequest = 1'b0; bus.readdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_read", 32'(bus.read), 32'd0);
      chk("reset_address", bus.address, 32'd0);
      chk("reset_be", 32'(bus.byteenable), 32'd0);
      reset = 1'b0;

      do_load(3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b0);
      chk("tp_lb", result, 32'hFFFF_FF80);
      do_load(3'd3, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 3, 1'b0);
      chk("tp_lhu", result, 32'h0000_BEEF);
      do_load(3'd6, 32'h0000_0101, 32'hAABB_CCDD, 32'h1122_3344, 1, 1'b0);
      chk("tp_lwl", result, 32'h3344_CCDD);
      do_load(3'd7, 32'h0000_0102, 32'hAABB_CCDD, 32'h1122_3344, 0, 1'b1);
      chk("tp_lwr", result, 32'hAABB_1122);
      do_load(3'd4, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 1'b1);
      do_load(3'd5, 32'h0000_0080, 32'h0, 32'h5555_AAAA, 1000, 1'b1);
      do_load(3'd5, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
      reset_mid_read();

      for (int i = 0; i < 300; i++) begin
         nw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
         do_load(3'($urandom), $urandom, $urandom, $urandom, nw, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
